// File: rtl/reg_reader_pkg.sv
// -----------------------------------------------------------------------------
// reg_reader_pkg
// Shared definitions for the reg_reader block: stamp width, default geometry,
// pointer-width helper and the FIFO entry layout.
// Optional feature macro: REG_READER_TIMESTAMP_EN (adds a 32-bit capture stamp
// to every entry).
// -----------------------------------------------------------------------------
package reg_reader_pkg;

   localparam int STAMP_W   = 32;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 4;

   // Pointer width for a power-of-two FIFO depth; pointers wrap modulo DEPTH.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int DEF_PTR_W = ptr_w(DEF_DEPTH);

   // Entry layout at the default width. reg_reader builds the same layout
   // locally so that a non-default WIDTH keeps the identical field order.
   typedef struct packed {
      logic [DEF_WIDTH-1:0] data;
`ifdef REG_READER_TIMESTAMP_EN
      logic [STAMP_W-1:0]   stamp;
`endif
   } reg_reader_entry_t;

endpackage

// File: rtl/reg_reader_fifo.sv
// -----------------------------------------------------------------------------
// reg_reader_fifo
// Synchronous DEPTH-entry FIFO, generic in its entry type. Full and empty are
// derived from the occupancy count. Head entry is presented straight from
// storage, so pop_data is registered state with no input-to-output path.
// Ports:
//   clock, reg_reset      clock and asynchronous active-high reset
//   push, push_data       write request and entry
//   pop                   read request (ignored while empty)
//   pop_data              head entry
//   full, empty, count    occupancy status
// -----------------------------------------------------------------------------
module reg_reader_fifo
   import reg_reader_pkg::*;
#(
   parameter type entry_t = logic [15:0],
   parameter int  DEPTH   = 4,
   localparam int PTR_W   = ptr_w(DEPTH)
) (
   input  logic         clock,
   input  logic         reg_reset,
   input  logic         push,
   input  entry_t       push_data,
   input  logic         pop,
   output entry_t       pop_data,
   output logic         full,
   output logic         empty,
   output logic [PTR_W:0] count
);

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               pop_ok;
   logic               push_ok;

   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);

   // A pop frees the tail slot in the same cycle, so a full FIFO still
   // accepts a push when it is also being read.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge clock or posedge reg_reset) begin
      if (reg_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         // NOTE: storage is reset too because the head entry drives the output
         // directly and must read as zero out of reset.
         mem    <= '{default: '0};
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, so pointer, count and storage update consistently.
         if (push_ok) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count <= count - 1'b1;
         end
      end
   end

   assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/reg_reader.sv
// -----------------------------------------------------------------------------
// reg_reader
// Watches a register's reg_out bus and captures each value change, or an
// explicit snapshot request, into a small FIFO read over valid/ready.
// Optional feature macro: REG_READER_TIMESTAMP_EN (free-running cycle counter,
// per-entry stamp and the rd_stamp output).
// Ports:
//   clock, reg_reset   clock and asynchronous active-high reset
//   reg_out            observed register value
//   snap_req           capture reg_out even when unchanged
//   rd_data, rd_valid  head entry and FIFO non-empty
//   rd_ready           consumer accepts the head entry
//   count              FIFO occupancy
//   ovf, ovf_clr       sticky dropped-capture flag and its clear
//   rd_stamp           capture cycle of the head entry (macro builds only)
// -----------------------------------------------------------------------------
module reg_reader
   import reg_reader_pkg::*;
#(
   parameter int  WIDTH = 16,
   parameter int  DEPTH = 4,
   localparam int PTR_W = ptr_w(DEPTH)
) (
   input  logic             clock,
   input  logic             reg_reset,
   input  logic [WIDTH-1:0] reg_out,
   input  logic             snap_req,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [PTR_W:0]   count,
   output logic             ovf,
   input  logic             ovf_clr
`ifdef REG_READER_TIMESTAMP_EN
   ,
   output logic [STAMP_W-1:0] rd_stamp
`endif
);

   // Same field order as reg_reader_entry_t, sized by WIDTH.
   typedef struct packed {
      logic [WIDTH-1:0]   data;
`ifdef REG_READER_TIMESTAMP_EN
      logic [STAMP_W-1:0] stamp;
`endif
   } entry_t;

   logic [WIDTH-1:0] last_q;
   logic             capture;
   logic             pop;
   logic             drop;
   logic             full;
   logic             empty;
   entry_t           push_entry;
   entry_t           head_entry;

   // last_q resets to 0, so a non-zero value on the first edge is a change.
   always_ff @(posedge clock or posedge reg_reset) begin
      if (reg_reset) begin
         last_q <= '0;
      end else begin
         last_q <= reg_out;
      end
   end

   // A change and a snapshot in the same cycle still make a single entry.
   assign capture = (reg_out != last_q) || snap_req;
   assign pop     = rd_valid && rd_ready;
   assign drop    = capture && full && !pop;

`ifdef REG_READER_TIMESTAMP_EN
   logic [STAMP_W-1:0] cycle_q;

   always_ff @(posedge clock or posedge reg_reset) begin
      if (reg_reset) begin
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_q + 1'b1;
      end
   end

   assign push_entry = '{data: reg_out, stamp: cycle_q};
   assign rd_stamp   = head_entry.stamp;
`else
   assign push_entry = '{data: reg_out};
`endif

   reg_reader_fifo #(
      .entry_t (entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reg_reset (reg_reset),
      .push      (capture),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head_entry),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   assign rd_data  = head_entry.data;
   assign rd_valid = !empty;

   // Set has priority over clear so a drop in the clearing cycle is not lost.
   always_ff @(posedge clock or posedge reg_reset) begin
      if (reg_reset) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_reader.sv
module tb_reg_reader;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   typedef struct {
      logic [15:0] val;
      logic        snap;
      logic        rdy;
      logic        clr;
      int          exp_count;
      logic        exp_ovf;
   } vec_t;

   typedef struct {
      logic [15:0] data;
      logic [31:0] stamp;
   } sb_t;

   logic             clock = 1'b0;
   logic             reg_reset;
   logic [WIDTH-1:0] reg_out;
   logic             snap_req;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             rd_ready;
   logic [2:0]       count;
   logic             ovf;
   logic             ovf_clr;
`ifdef REG_READER_TIMESTAMP_EN
   logic [31:0]      rd_stamp;
   int unsigned      m_cyc;
`endif

   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   sb_t  sb[$];
   logic [15:0] m_last;

   reg_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock     (clock),
      .reg_reset (reg_reset),
      .reg_out   (reg_out),
      .snap_req  (snap_req),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .count     (count),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
`ifdef REG_READER_TIMESTAMP_EN
      ,
      .rd_stamp  (rd_stamp)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic [15:0] val, input logic snap, input logic rdy,
                          input logic clr, input int cnt, input logic o);
      vec_t v;
      v.val = val; v.snap = snap; v.rdy = rdy; v.clr = clr;
      v.exp_count = cnt; v.exp_ovf = o;
      vecs.push_back(v);
   endtask

   // One clock with the inputs currently driven. The scoreboard predicts
   // captures and pops from the inputs, then the edge is taken and outputs
   // settle before the caller compares them.
   task automatic cycle();
      bit  cap;
      bit  do_pop;
      sb_t e;
      cap    = (reg_out != m_last) || snap_req;
      do_pop = (sb.size() != 0) && rd_ready;
      if (sb.size() != 0) begin
         check(do_pop ? "pop_data" : "held_data", {16'h0, rd_data}, {16'h0, sb[0].data});
`ifdef REG_READER_TIMESTAMP_EN
         check("rd_stamp", rd_stamp, sb[0].stamp);
`endif
      end
      if (do_pop) void'(sb.pop_front());
      if (cap && sb.size() < DEPTH) begin
         e.data  = reg_out;
         e.stamp = '0;
`ifdef REG_READER_TIMESTAMP_EN
         e.stamp = m_cyc;
`endif
         sb.push_back(e);
      end
      m_last = reg_out;
      @(posedge clock);
      #1;
`ifdef REG_READER_TIMESTAMP_EN
      m_cyc++;
`endif
   endtask

   initial begin
      reg_reset = 1'b1;
      reg_out   = '0;
      snap_req  = 1'b0;
      rd_ready  = 1'b0;
      ovf_clr   = 1'b0;
      m_last    = '0;
`ifdef REG_READER_TIMESTAMP_EN
      m_cyc     = 0;
`endif

      // Idle with zero input: nothing captured.
      repeat (5) add_vec(16'h0000, 0, 1, 0, 0, 0);
      // Single change, popped on the following edge.
      add_vec(16'h00A5, 0, 1, 0, 1, 0);
      add_vec(16'h00A5, 0, 1, 0, 0, 0);
      // Overflow: fifth capture dropped, drain 1..4, clear, pop while empty.
      add_vec(16'h0001, 0, 0, 0, 1, 0);
      add_vec(16'h0002, 0, 0, 0, 2, 0);
      add_vec(16'h0003, 0, 0, 0, 3, 0);
      add_vec(16'h0004, 0, 0, 0, 4, 0);
      add_vec(16'h0005, 0, 0, 0, 4, 1);
      for (int c = 3; c >= 0; c--) add_vec(16'h0005, 0, 1, 0, c, 1);
      add_vec(16'h0005, 0, 0, 1, 0, 0);
      add_vec(16'h0005, 0, 1, 0, 0, 0);
      // Full FIFO with change and pop in the same cycle: no drop.
      add_vec(16'h0006, 0, 0, 0, 1, 0);
      add_vec(16'h0007, 0, 0, 0, 2, 0);
      add_vec(16'h0008, 0, 0, 0, 3, 0);
      add_vec(16'h0009, 0, 0, 0, 4, 0);
      add_vec(16'h000A, 0, 1, 0, 4, 0);
      for (int c = 3; c >= 0; c--) add_vec(16'h000A, 0, 1, 0, c, 0);
      // Drop and clear in the same cycle: set wins, then a plain clear.
      add_vec(16'h000B, 0, 0, 0, 1, 0);
      add_vec(16'h000C, 0, 0, 0, 2, 0);
      add_vec(16'h000D, 0, 0, 0, 3, 0);
      add_vec(16'h000E, 0, 0, 0, 4, 0);
      add_vec(16'h000F, 0, 0, 1, 4, 1);
      add_vec(16'h000F, 0, 0, 1, 4, 0);
      for (int c = 3; c >= 0; c--) add_vec(16'h000F, 0, 1, 0, c, 0);
      // Snapshots of a steady value, then snapshot coinciding with a change.
      add_vec(16'h1234, 0, 0, 0, 1, 0);
      add_vec(16'h1234, 0, 1, 0, 0, 0);
      add_vec(16'h1234, 1, 0, 0, 1, 0);
      add_vec(16'h1234, 0, 0, 0, 1, 0);
      add_vec(16'h1234, 1, 0, 0, 2, 0);
      add_vec(16'h4321, 1, 0, 0, 3, 0);
      for (int c = 2; c >= 0; c--) add_vec(16'h4321, 0, 1, 0, c, 0);

      repeat (3) @(posedge clock);
      #1;
      check("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
      check("reset_rd_data", {16'h0, rd_data}, 32'h0);
      check("reset_count", {29'h0, count}, 32'h0);
      check("reset_ovf", {31'h0, ovf}, 32'h0);
`ifdef REG_READER_TIMESTAMP_EN
      check("reset_rd_stamp", rd_stamp, 32'h0);
`endif
      reg_reset = 1'b0;

      foreach (vecs[i]) begin
         reg_out  = vecs[i].val;
         snap_req = vecs[i].snap;
         rd_ready = vecs[i].rdy;
         ovf_clr  = vecs[i].clr;
         cycle();
         check($sformatf("count[%0d]", i), {29'h0, count}, vecs[i].exp_count);
         check($sformatf("ovf[%0d]", i), {31'h0, ovf}, {31'h0, vecs[i].exp_ovf});
         check($sformatf("rd_valid[%0d]", i), {31'h0, rd_valid},
               {31'h0, (vecs[i].exp_count != 0)});
      end
      snap_req = 1'b0;
      ovf_clr  = 1'b0;

      // Reset mid-operation with a full FIFO and ovf set.
      rd_ready = 1'b0;
      for (int v = 1; v <= 5; v++) begin
         reg_out = 16'(v);
         cycle();
      end
      check("pre_reset_count", {29'h0, count}, 32'd4);
      check("pre_reset_ovf", {31'h0, ovf}, 32'h1);
      reg_reset = 1'b1;
      #1;
      check("async_reset_rd_valid", {31'h0, rd_valid}, 32'h0);
      check("async_reset_count", {29'h0, count}, 32'h0);
      check("async_reset_ovf", {31'h0, ovf}, 32'h0);
      sb.delete();
      m_last = '0;
      @(posedge clock);
      #1;
      reg_reset = 1'b0;
`ifdef REG_READER_TIMESTAMP_EN
      m_cyc = 0;
`endif
      // reg_out is still 5: first edge after reset sees a non-zero change.
      cycle();
      check("post_reset_count", {29'h0, count}, 32'd1);
      check("post_reset_data", {16'h0, rd_data}, 32'h5);
      rd_ready = 1'b1;
      cycle();
      check("post_reset_drain", {29'h0, count}, 32'h0);

      // Sparse changes to exercise distinct capture stamps.
      rd_ready = 1'b0;
      repeat (2) cycle();
      reg_out = 16'h0077;
      cycle();
      repeat (3) cycle();
      reg_out = 16'h0088;
      cycle();
      check("sparse_count", {29'h0, count}, 32'd2);
      rd_ready = 1'b1;
      repeat (3) cycle();
      check("sparse_drain", {29'h0, count}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_reader.md
# reg_reader

Read-side companion to `register`: watches the register's `reg_out` bus, captures every value change (or an explicit snapshot request) into a small FIFO, and delivers captured values to a consumer over a valid/ready handshake. It sits between a `register` instance and a monitor, bus bridge or scoreboard, and it lets software or testbenches observe the register's write history without polling every cycle.

## Interface
Parameters:
- `WIDTH`, 16: width of the observed register and of `rd_data`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reg_reset`  in  1  asynchronous, active-high reset.
- `reg_out`  in  WIDTH  observed register value; connects to `register.reg_out`.
- `snap_req`  in  1  one-cycle request to capture the current `reg_out` even if it is unchanged.
- `rd_data`  out  WIDTH  head-of-FIFO value.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  consumer accepts `rd_data` when `rd_valid` and `rd_ready` are both high.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `ovf`  out  1  sticky flag: at least one capture was dropped.
- `ovf_clr`  in  1  clears `ovf`.
- `rd_stamp`  out  32  timestamp of the head entry; present only with `REG_READER_TIMESTAMP_EN`.

## Operation
- Internal `last_q` holds `reg_out` from the previous edge. It resets to 0 and updates on every edge.
- Capture event at an edge: `reg_out != last_q`, or `snap_req` high. Both conditions true in the same cycle produce one entry.
- A value other than 0 on the first edge after reset counts as a change.
- On a capture event, the sampled `reg_out` value is written at the tail:
  - if the FIFO is not full, the entry is pushed;
  - if it is full, the entry is dropped and `ovf` is set;
  - if it is full and a pop happens in the same cycle, the push is accepted and `ovf` is not set.
- Pop: when `rd_valid && rd_ready` at an edge, the head advances.
- Push and pop in the same cycle leave `count` unchanged.
- Pop while empty is ignored.
- `ovf` behaviour:
  - set by a dropped capture;
  - cleared by `ovf_clr`;
  - a drop and `ovf_clr` in the same cycle leave `ovf` set (set wins).
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full and empty are derived from `count`.
- No state machine beyond the FIFO pointers. The block is always capturing.

## Timing
- Reset values:
  - `rd_valid` = 0, `rd_data` = 0, `count` = 0, `ovf` = 0, `last_q` = 0;
  - pointers = 0, `rd_stamp` = 0.
- Latency: a change present on `reg_out` before edge k gives `rd_valid` = 1 and `rd_data` = that value after edge k (1 cycle).
- `rd_data`/`rd_valid` come straight from FIFO storage and pointers (registered). There is no combinational path from `reg_out` or `rd_ready` to the outputs.
- `rd_data` holds stable while `rd_valid` is high and `rd_ready` is low.
- Back-to-back changes on consecutive cycles produce consecutive entries. Throughput is one capture per cycle.
- Reset asserted mid-operation:
  - the FIFO empties and `ovf` clears immediately (asynchronously);
  - contents are discarded.

## Configuration
- `REG_READER_TIMESTAMP_EN` defined:
  - a 32-bit free-running cycle counter is added; it resets to 0, increments every cycle and wraps at 2^32;
  - each entry stores the counter value from its capture edge;
  - `rd_stamp` presents the stamp of the head entry.
- Not defined: the counter, the stamp storage and the `rd_stamp` port are all absent. Capture behaviour is identical in both builds.

## Structure
- `reg_reader_pkg` holds:
  - `STAMP_W` = 32;
  - `reg_reader_entry_t`, a struct of data plus stamp under the macro;
  - the helper localparam for pointer width.
- Sub-module `reg_reader_fifo`: a synchronous DEPTH-entry FIFO with push/pop/full/empty/count. It is written generically in the entry type, and `reg_reader` adds the change detection and the `ovf` logic.

## Test plan
- Reset, then hold `reg_out`=0 for 5 cycles → `rd_valid`=0, `count`=0, `ovf`=0.
- `reg_out` goes 0→0x00A5 with `rd_ready`=1 → one cycle later `rd_valid`=1, `rd_data`=0x00A5, popped on the next edge, `count` back to 0.
- `rd_ready`=0; `reg_out` = 1,2,3,4,5 on consecutive cycles → `count`=4 and `ovf`=1. Draining then yields 1,2,3,4. Pulsing `ovf_clr` then gives `ovf`=0.
- FIFO full, change and pop in the same cycle → `count` stays 4 and `ovf` stays 0. The new value appears last when drained.
- `reg_out` steady at 0x1234 and `snap_req` pulsed twice → two entries, both 0x1234. Pulsing `snap_req` together with a change to 0x4321 → one entry, 0x4321.
- With `REG_READER_TIMESTAMP_EN`: changes at cycles 3 and 7 after reset → `rd_stamp` 3 then 7. Asserting `reg_reset` while 2 entries are held → `rd_valid`=0 and `count`=0 immediately.
